irq_encoder_8to3: RTL and testbench

- Sequential counterpart of the 3-to-8 decoder: converts one-hot or multi-hot request lines into a binary index, one event at a time.
- Level requests are latched into a pending register.
- The highest-priority pending index is presented on a valid/ready output port. The accepted bit is cleared.
- Sits between peripheral event lines and a consumer such as a controller FSM or interrupt handler.

---
 rtl/irq_encoder_8to3.sv | 166 ++++++++++++++++
 tb/tb_irq_encoder_8to3.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_encoder_8to3.sv
// Latches level request lines and hands out one pending index per accept on a valid/ready port.
// Define IRQ_ENC_RR_PRI_EN for round-robin selection; otherwise lowest index wins.
module irq_encoder_8to3 #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             clr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic [N-1:0]     pending,
  output logic             overflow
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_pending;
  logic [N-1:0]     r_onehot;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic             r_overflow;

  logic             w_accept;
  logic [N-1:0]     w_acc_mask;
  logic [N-1:0]     w_pend_next;
  logic             w_overflow_hit;
  logic             w_cand_valid;
  logic [IDX_W-1:0] w_cand_idx;

  function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = (idx == IDX_W'(i));
    end
    return v;
  endfunction

  // Accept qualification and next pending set; a request on the accepted bit re-arms it
  always_comb begin
    w_accept   = r_valid & out_ready;
    w_acc_mask = w_accept ? r_onehot : {N{1'b0}};
    if (clr) begin
      w_pend_next = '0;
    end else begin
      w_pend_next = (r_pending & ~w_acc_mask) | req;
    end
    w_overflow_hit = |(req & r_pending & ~w_acc_mask);
    w_cand_valid   = |w_pend_next;
  end

`ifdef IRQ_ENC_RR_PRI_EN
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_start;

  function automatic logic [IDX_W-1:0] idx_wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N - 1)) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    s = (s >= N) ? s - N : s;
    return IDX_W'(s);
  endfunction

  // Round-robin search: starts just past the index being accepted, else at the pointer
  always_comb begin
    w_start    = w_accept ? idx_wrap_inc(r_idx) : r_ptr;
    w_cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand_idx = w_pend_next[wrap_add(w_start, k)] ? wrap_add(w_start, k) : w_cand_idx;
    end
  end

  // Pointer follows the last accepted index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= idx_wrap_inc(r_idx);
    end else begin
      r_ptr <= r_ptr;
    end
  end
`else
  // Fixed priority search: scanning downward leaves the lowest set index
  always_comb begin
    w_cand_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_cand_idx = w_pend_next[i] ? IDX_W'(i) : w_cand_idx;
    end
  end
`endif

  // Pending register, sticky overflow and the presenting FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_onehot   <= '0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_onehot   <= '0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= w_pend_next;
      r_overflow <= r_overflow | w_overflow_hit;
      case (r_state)
        ST_IDLE: begin
          if (r_pending != '0) begin
            r_state  <= ST_PRESENT;
            r_valid  <= 1'b1;
            r_idx    <= w_cand_idx;
            r_onehot <= idx_to_onehot(w_cand_idx);
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_PRESENT: begin
          // A presented event is never pre-empted; it only changes on accept
          if (w_accept && w_cand_valid) begin
            r_idx    <= w_cand_idx;
            r_onehot <= idx_to_onehot(w_cand_idx);
          end else if (w_accept) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
          end else begin
            r_state  <= ST_PRESENT;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_valid  <= 1'b0;
          r_idx    <= '0;
          r_onehot <= '0;
        end
      endcase
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign pending    = r_pending;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Bench for irq_encoder_8to3: directed scenarios with literal expectations plus random traffic
// compared every cycle against an index-level behavioural model.
module tb_irq_encoder_8to3;
  localparam int N = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       clr;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic [7:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fails  = 0;

  irq_encoder_8to3 #(.N(8), .IDX_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .clr        (clr),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .pending    (pending),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model state: pending flags, presented index (-1 = nothing presented), overflow, pointer
  logic [7:0] mp   = 8'd0;
  int         mcur = -1;
  logic       movf = 1'b0;
  int         mptr = 0;

  function automatic bit acc_now();
    return (mcur >= 0) && (out_ready == 1'b1);
  endfunction

  function automatic bit taken(input int i);
    return acc_now() && (i == mcur);
  endfunction

  function automatic int pick(input logic [7:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] f_pend();
    logic [7:0] v;
    v = 8'd0;
    if (clr) return 8'd0;
    for (int i = 0; i < N; i++) v[i] = (mp[i] && !taken(i)) || req[i];
    return v;
  endfunction

  function automatic logic f_ovf();
    logic o;
    o = movf;
    if (clr) return 1'b0;
    for (int i = 0; i < N; i++) if (req[i] && mp[i] && !taken(i)) o = 1'b1;
    return o;
  endfunction

  function automatic int f_ptr();
`ifdef IRQ_ENC_RR_PRI_EN
    if (clr) return 0;
    if (acc_now()) return (mcur + 1) % N;
    return mptr;
`else
    return 0;
`endif
  endfunction

  function automatic int f_cur();
    if (clr) return -1;
    if (mcur < 0) return (mp != 8'd0) ? pick(f_pend(), mptr) : -1;
    if (acc_now()) return pick(f_pend(), f_ptr());
    return mcur;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp   <= 8'd0;
      mcur <= -1;
      movf <= 1'b0;
      mptr <= 0;
    end else begin
      mp   <= f_pend();
      mcur <= f_cur();
      movf <= f_ovf();
      mptr <= f_ptr();
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid", 32'(out_valid), 32'(mcur >= 0));
      chk("model_onehot", 32'(out_onehot), (mcur >= 0) ? (32'd1 << mcur) : 32'd0);
      chk("model_pending", 32'(pending), 32'(mp));
      chk("model_overflow", 32'(overflow), 32'(movf));
      if (mcur >= 0) chk("model_idx", 32'(out_idx), 32'(mcur));
    end
  end

  task automatic tick(input logic [7:0] r, input logic c, input logic rd);
    @(negedge clk);
    req       = r;
    clr       = c;
    out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_present(input string name, input logic v, input logic [2:0] idx);
    chk({name, "_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      chk({name, "_idx"}, 32'(out_idx), 32'(idx));
      chk({name, "_onehot"}, 32'(out_onehot), 32'd1 << idx);
    end else begin
      chk({name, "_onehot"}, 32'(out_onehot), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b1; req = 8'd0; clr = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_onehot", 32'(out_onehot), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Single event
    tick(8'h00, 1'b1, 1'b0);
    tick(8'h20, 1'b0, 1'b1);
    chk("single_pend", 32'(pending), 32'h20);
    chk_present("single_t1", 1'b0, 3'd0);
    tick(8'h00, 1'b0, 1'b1);
    chk_present("single_t2", 1'b1, 3'd5);
    tick(8'h00, 1'b0, 1'b1);
    chk_present("single_t3", 1'b0, 3'd0);
    chk("single_pend_end", 32'(pending), 32'h00);

    // Burst drain
    tick(8'h00, 1'b1, 1'b0);
    tick(8'hA5, 1'b0, 1'b1);
    tick(8'h00, 1'b0, 1'b1); chk_present("burst0", 1'b1, 3'd0);
    tick(8'h00, 1'b0, 1'b1); chk_present("burst1", 1'b1, 3'd2);
    tick(8'h00, 1'b0, 1'b1); chk_present("burst2", 1'b1, 3'd5);
    tick(8'h00, 1'b0, 1'b1); chk_present("burst3", 1'b1, 3'd7);
    tick(8'h00, 1'b0, 1'b1); chk_present("burst_end", 1'b0, 3'd0);

    // Stall with a higher-priority arrival
    tick(8'h00, 1'b1, 1'b0);
    tick(8'h10, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b0); chk_present("stall0", 1'b1, 3'd4);
    tick(8'h02, 1'b0, 1'b0); chk_present("stall1", 1'b1, 3'd4);
    for (int s = 0; s < 3; s++) begin
      tick(8'h00, 1'b0, 1'b0); chk_present("stall_hold", 1'b1, 3'd4);
    end
    chk("stall_pend", 32'(pending), 32'h12);
    tick(8'h00, 1'b0, 1'b1); chk_present("stall_next", 1'b1, 3'd1);
    tick(8'h00, 1'b0, 1'b1); chk_present("stall_end", 1'b0, 3'd0);

    // Re-arm on the accepted bit
    tick(8'h00, 1'b1, 1'b0);
    tick(8'h08, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b0); chk_present("rearm0", 1'b1, 3'd3);
    tick(8'h08, 1'b0, 1'b1); chk_present("rearm1", 1'b1, 3'd3);
    chk("rearm_ovf", 32'(overflow), 32'd0);
    tick(8'h00, 1'b0, 1'b1); chk_present("rearm_end", 1'b0, 3'd0);
    chk("rearm_ovf_end", 32'(overflow), 32'd0);

    // Overflow: second pulse before any accept
    tick(8'h00, 1'b1, 1'b0);
    tick(8'h08, 1'b0, 1'b0);
    tick(8'h08, 1'b0, 1'b0); chk("ovf_set", 32'(overflow), 32'd1);
    tick(8'h00, 1'b0, 1'b1); chk("ovf_hold", 32'(overflow), 32'd1);
    tick(8'h00, 1'b1, 1'b0); chk("ovf_clr", 32'(overflow), 32'd0);
    chk_present("ovf_clr", 1'b0, 3'd0);

    // Held pair of requests: priority policy visible
    tick(8'h00, 1'b1, 1'b0);
    tick(8'h81, 1'b0, 1'b1);
    tick(8'h81, 1'b0, 1'b1); chk_present("pair0", 1'b1, 3'd0);
`ifdef IRQ_ENC_RR_PRI_EN
    tick(8'h81, 1'b0, 1'b1); chk_present("pair1", 1'b1, 3'd7);
    tick(8'h81, 1'b0, 1'b1); chk_present("pair2", 1'b1, 3'd0);
    tick(8'h81, 1'b0, 1'b1); chk_present("pair3", 1'b1, 3'd7);
`else
    tick(8'h81, 1'b0, 1'b1); chk_present("pair1", 1'b1, 3'd0);
    tick(8'h81, 1'b0, 1'b1); chk_present("pair2", 1'b1, 3'd0);
    tick(8'h81, 1'b0, 1'b1); chk_present("pair3", 1'b1, 3'd0);
`endif

    // Asynchronous reset while presenting
    tick(8'h00, 1'b1, 1'b0);
    tick(8'hFF, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b0);
    chk("prerst_pend", 32'(pending), 32'hFF);
    chk_present("prerst", 1'b1, 3'd0);
    @(negedge clk);
    req = 8'h00; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_present("async_rst", 1'b0, 3'd0);
    chk("async_rst_idx", 32'(out_idx), 32'd0);
    chk("async_rst_pend", 32'(pending), 32'd0);
    chk("async_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick(8'h00, 1'b0, 1'b1); chk_present("postrst1", 1'b0, 3'd0);
    tick(8'h00, 1'b0, 1'b1); chk_present("postrst2", 1'b0, 3'd0);

    // Random traffic, checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req       = 8'($urandom & $urandom & $urandom);
      clr       = ($urandom_range(40) == 0);
      out_ready = (c % 500 < 250) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
    end
    tick(8'h00, 1'b1, 1'b0);
    tick(8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
